psum_deskew_drain: RTL and testbench

PSUM_DESKEW_DRAIN -- requirements
Module: psum_deskew_drain

---
 rtl/npu_pkg.sv | 38 +++
 rtl/row_fifo.sv | 49 ++++
 rtl/psum_deskew_drain.sv | 163 ++++++++++++++++
 tb/tb_psum_deskew_drain.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: tile geometry, datapath widths, drain FSM states
// and the requantizer shared by the deskew/drain path.
package npu_pkg;

  localparam int N      = 10;
  localparam int ROWS   = 10;
  localparam int OUT_W  = 8;
  localparam int PSUM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;

  // round-half-up shift in PSUM_W+1 bits, optional relu, saturate
  function automatic logic [OUT_W-1:0] requant(
    input logic [PSUM_W-1:0] x,
    input logic [3:0]        sh,
    input logic              relu
  );
    logic signed [PSUM_W:0] s;
    logic signed [PSUM_W:0] rnd;
    rnd = '0;
    if (sh != 4'd0)
      rnd = $signed((PSUM_W+1)'(1) << (sh - 4'd1));
    s = $signed({x[PSUM_W-1], x}) + rnd;
    s = s >>> sh;
    if (relu && s[PSUM_W])
      s = '0;
    if (!s[PSUM_W] && (|s[PSUM_W-1:OUT_W-1]))
      return {1'b0, {(OUT_W-1){1'b1}}};
    if (s[PSUM_W] && !(&s[PSUM_W-1:OUT_W-1]))
      return {1'b1, {(OUT_W-1){1'b0}}};
    return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/row_fifo.sv
// row_fifo: power-of-two FIFO of finished rows; a push into a
// full FIFO is taken when a pop happens in the same cycle.
module row_fifo #(
  parameter int W     = 85,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         wr_go;
  logic         rd_go;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_go = rd_en_i && !empty_o;
  assign wr_go = wr_en_i && (!full_o || rd_en_i);

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_go) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_go) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_go)
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/psum_deskew_drain.sv
// psum_deskew_drain: realigns skewed bottom-row partial sums into
// rows, requantizes them and drains them through a row FIFO.
module psum_deskew_drain #(
  parameter int N          = npu_pkg::N,
  parameter int ROWS       = npu_pkg::ROWS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              psum_valid,
  input  logic [N-1:0][npu_pkg::PSUM_W-1:0] psum_in,
  input  logic [3:0]                        shift,
  input  logic                              relu_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N-1:0][npu_pkg::OUT_W-1:0]  out_row,
  output logic [3:0]                        out_row_idx,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow_err
);

  import npu_pkg::*;

  localparam int RW     = N * OUT_W;
  localparam int FW     = RW + 4 + 1;
  localparam int KW     = $clog2(ROWS + N);
  localparam int LAST_K = ROWS + N - 2;

  state_e                     state_q;
  logic [KW-1:0]              k_q;
  logic [3:0]                 shift_q;
  logic                       relu_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       ovf_q;

  logic [N-1:0][PSUM_W-1:0]   aligned;
  logic [N-1:0][OUT_W-1:0]    quant;
  logic                       stage_q;
  logic [N-1:0][OUT_W-1:0]    stage_row_q;
  logic [3:0]                 stage_idx_q;
  logic                       stage_last_q;

  logic                       accept;
  logic                       row_done;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [FW-1:0]              head;

  assign accept   = (state_q == ST_CAPTURE) && psum_valid;
  assign row_done = accept && (k_q >= KW'(N - 1));

  // lane j waits N-1-j accepted samples for the rest of its row
  for (genvar j = 0; j < N - 1; j++) begin : g_lane
    localparam int D = N - 1 - j;
    logic [PSUM_W-1:0] line_q [D];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < D; i++) line_q[i] <= '0;
      end else if (accept) begin
        line_q[0] <= psum_in[j];
        for (int i = 1; i < D; i++) line_q[i] <= line_q[i-1];
      end
    end
    assign aligned[j] = line_q[D-1];
  end
  assign aligned[N-1] = psum_in[N-1];

  always_comb begin
    quant = '0;
    for (int j = 0; j < N; j++)
      quant[j] = requant(aligned[j], shift_q, relu_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= 1'b0;
      stage_row_q  <= '0;
      stage_idx_q  <= '0;
      stage_last_q <= 1'b0;
    end else begin
      stage_q <= row_done;
      if (row_done) begin
        stage_row_q  <= quant;
        stage_idx_q  <= 4'(k_q - KW'(N - 1));
        stage_last_q <= (k_q == KW'(LAST_K));
      end
    end
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  row_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (stage_q),
    .wr_data_i ({stage_last_q, stage_idx_q, stage_row_q}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign out_row     = out_valid ? head[RW-1:0] : '0;
  assign out_row_idx = out_valid ? head[RW+3:RW] : 4'd0;
  assign out_last    = out_valid && head[FW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stage_q && full && !pop)
        ovf_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CAPTURE;
            busy_q  <= 1'b1;
            k_q     <= '0;
            shift_q <= shift;
            relu_q  <= relu_en;
            ovf_q   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (accept) begin
            k_q <= k_q + 1'b1;
            if (k_q == KW'(LAST_K))
              state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (empty && !stage_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_psum_deskew_drain.sv
// tb_psum_deskew_drain: directed tiles with a row scoreboard and an
// independent integer requantization model.
module tb_psum_deskew_drain;

  localparam int N     = 10;
  localparam int ROWS  = 10;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 psum_valid;
  logic [N-1:0][15:0]   psum_in;
  logic [3:0]           shift;
  logic                 relu_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0][7:0]    out_row;
  logic [3:0]           out_row_idx;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic                 overflow_err;

  typedef struct packed {
    logic [N-1:0][7:0] row;
    logic [3:0]        idx;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   passed    = 0;
  int   done_cnt  = 0;
  int   cyc       = 0;
  int   acc_cyc   = 0;
  int   first_cyc = -1;

  psum_deskew_drain #(
    .N          (N),
    .ROWS       (ROWS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .psum_valid   (psum_valid),
    .psum_in      (psum_in),
    .shift        (shift),
    .relu_en      (relu_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_row_idx  (out_row_idx),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_q(input int x, input int sh,
                                         input bit relu);
    int v;
    v = x;
    if (sh > 0) v = v + (1 << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic int lane_val(input int pat, input int k,
                                  input int j);
    case (pat)
      0:       return 100;
      1:       return 100 * (k - j) + j;
      2:       return -300;
      default: return 3000 * (k - j) - 7000 + 113 * j;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (out_valid && first_cyc < 0) first_cyc = cyc;
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        check("row_unexpected_sb_size", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("row_data", out_row, e.row);
        check("row_idx", out_row_idx, e.idx);
        check("row_last", out_last, e.last);
      end
    end
  end

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_idx"}, out_row_idx, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf"}, overflow_err, 0);
  endtask

  task automatic run_tile(input int pat, input int sh, input bit relu,
                          input bit gap, input int keep,
                          input int abort_at);
    exp_t e;
    int   r;
    first_cyc = -1;
    tick();
    start   = 1'b1;
    shift   = 4'(sh);
    relu_en = relu;
    tick();
    start   = 1'b0;
    shift   = ~4'(sh);
    relu_en = !relu;
    for (int k = 0; k <= ROWS + N - 2; k++) begin
      psum_valid = 1'b1;
      for (int j = 0; j < N; j++)
        psum_in[j] = 16'(lane_val(pat, k, j));
      start = (k == 5);
      if (k == N - 1) acc_cyc = cyc;
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        psum_valid = 1'b0;
        start      = 1'b0;
        return;
      end
      if (k >= N - 1 && (k - (N - 1)) < keep) begin
        r = k - (N - 1);
        for (int j = 0; j < N; j++)
          e.row[j] = model_q(lane_val(pat, r + j, j), sh, relu);
        e.idx  = 4'(r);
        e.last = (r == ROWS - 1);
        sb.push_back(e);
      end
      if (k == 0) begin
        @(negedge clk);
        check("busy_capture", busy, 1);
      end
      tick();
      if (gap) begin
        psum_valid = 1'b0;
        psum_in    = '1;
        start      = 1'b0;
        tick();
      end
    end
    psum_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic finish_tile(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != d0, 1);
    repeat (4) tick();
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int d0;
    rst        = 1'b1;
    start      = 1'b0;
    psum_valid = 1'b0;
    psum_in    = '0;
    shift      = 4'd0;
    relu_en    = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0;

    d0 = done_cnt;
    run_tile(0, 2, 0, 0, ROWS, -1);
    finish_tile("const25", d0);
    check("first_row_latency", first_cyc - acc_cyc, 2);
    check("const25_ovf", overflow_err, 0);

    d0 = done_cnt;
    run_tile(1, 3, 0, 0, ROWS, -1);
    finish_tile("deskew", d0);

    d0 = done_cnt;
    run_tile(2, 0, 0, 0, ROWS, -1);
    finish_tile("neg_sat", d0);

    d0 = done_cnt;
    run_tile(2, 0, 1, 0, ROWS, -1);
    finish_tile("neg_relu", d0);

    d0 = done_cnt;
    run_tile(1, 1, 0, 1, ROWS, -1);
    finish_tile("gapped", d0);

    d0 = done_cnt;
    run_tile(3, 3, 0, 0, ROWS, -1);
    finish_tile("sat_mix", d0);

    out_ready = 1'b0;
    d0 = done_cnt;
    run_tile(1, 0, 0, 0, DEPTH, -1);
    repeat (10) tick();
    @(negedge clk);
    check("bp_ovf", overflow_err, 1);
    check("bp_valid", out_valid, 1);
    check("bp_idx", out_row_idx, 0);
    check("bp_row_a", out_row, sb[0].row);
    check("bp_no_done", done_cnt - d0, 0);
    tick();
    @(negedge clk);
    check("bp_row_b", out_row, sb[0].row);
    out_ready = 1'b1;
    finish_tile("bp_drain", d0);
    check("bp_ovf_sticky", overflow_err, 1);

    out_ready = 1'b0;
    d0 = done_cnt;
    run_tile(1, 2, 0, 0, 0, 12);
    check_reset("midrst");
    repeat (30) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);
    sb.delete();
    out_ready = 1'b1;

    d0 = done_cnt;
    run_tile(1, 2, 1, 0, ROWS, -1);
    finish_tile("fresh", d0);
    check("fresh_ovf", overflow_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d checks=%0d",
             passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
